// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - word-indexed instruction fetch with a 2-entry output FIFO
// Fetches RD at pc each cycle there is room, stalls on backpressure, and handles redirects and out-of-range faults.
module instruction_fetch #(
    parameter int DEPTH    = 5,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic signed [31:0] A,
    input  logic        [31:0] RD,
    input  logic               redirect,
    input  logic signed [31:0] redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [31:0] out_instr,
    output logic        [31:0] out_pc,
    output logic               halted,
    output logic               fault
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE,
        FAULT
    } state_t;

    localparam logic signed [31:0] DEPTH_S    = 32'(DEPTH);
    localparam logic signed [31:0] RESET_PC_S = 32'(RESET_PC);

    state_t             state;
    state_t             state_next;
    logic signed [31:0] pc;
    logic signed [31:0] pc_next;
    logic signed [31:0] pc_inc;
    logic        [31:0] instr_mem [2];
    logic        [31:0] pc_mem    [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic        [1:0]  count;
    logic               pop;
    logic               pop_eff;
    logic               push;
    logic               flush;
    logic               target_ok;

    assign A         = pc;
    assign pc_inc    = pc + 32'sd1;
    assign target_ok = (redirect_target >= 32'sd0) && (redirect_target < DEPTH_S);
    assign pop       = (count != 2'd0) && out_ready;
    assign pop_eff   = pop && !flush;

    assign out_valid = (count != 2'd0);
    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];
    assign halted    = (state == DONE) || (state == FAULT);
    assign fault     = (state == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Redirect outranks both fetch and pop; FAULT is sticky until reset.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect && (state != FAULT)) begin
            flush = 1'b1;
            if (target_ok) begin
                pc_next    = redirect_target;
                state_next = RUN;
            end else begin
                state_next = FAULT;
            end
        end else begin
            case (state)
                RUN: begin
                    if (!((count == 2'd2) && !pop)) begin
                        push    = 1'b1;
                        pc_next = pc_inc;
                        if (pc_inc == DEPTH_S) begin
                            state_next = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (count == 2'd0) begin
                        state_next = DONE;
                    end
                end
                DONE:    state_next = DONE;
                FAULT:   state_next = FAULT;
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC_S;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                instr_mem[i] <= 32'd0;
                pc_mem[i]    <= 32'd0;
            end
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= RD;
                pc_mem[wr_ptr]    <= 32'(pc);
                wr_ptr            <= ~wr_ptr;
            end
            if (pop_eff) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop_eff};
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic               clk;
    logic               rst_n;
    logic signed [31:0] A;
    logic        [31:0] RD;
    logic               redirect;
    logic signed [31:0] redirect_target;
    logic               out_valid;
    logic               out_ready;
    logic        [31:0] out_instr;
    logic        [31:0] out_pc;
    logic               halted;
    logic               fault;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(.DEPTH(5), .RESET_PC(0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .A               (A),
        .RD              (RD),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .halted          (halted),
        .fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word k holds A000_0000 + k.
    always_comb begin
        if (A >= 0 && A < 8) RD = 32'hA000_0000 + 32'(A);
        else                 RD = 32'hDEAD_BEEF;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_target = 0;
        out_ready = ready;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_checks++; if (A !== 32'sd0) begin n_fail++; $display("FAIL reset_A: got %0d want 0", A); end
        n_checks++; if (out_instr !== 32'd0 || out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_out: got instr %h pc %0d want 0 0", out_instr, out_pc); end
        n_checks++; if (halted !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got halted %0b fault %0b want 0 0", halted, fault); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int waited;
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'(k) || out_instr !== 32'hA000_0000 + 32'(k)) begin
                n_fail++; $display("FAIL stream_%0d: got v %0b pc %0d instr %h want 1 %0d %h", k, out_valid, out_pc, out_instr, k, 32'hA000_0000 + 32'(k));
            end
        end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %0b want 0", out_valid); end
        waited = 0;
        while (halted !== 1'b1 && waited < 10) begin step(); waited++; end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL stream_halted: got %0b want 1", halted); end
        step(); step(); step();
        n_checks++; if (A !== 32'sd5 || out_valid !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL stream_done_hold: got A %0d v %0b f %0b want 5 0 0", A, out_valid, fault); end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) step();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0) begin n_fail++; $display("FAIL bp_head: got v %0b pc %0d want 1 0", out_valid, out_pc); end
        n_checks++; if (A !== 32'sd2) begin n_fail++; $display("FAIL bp_stall_A: got %0d want 2", A); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_pc !== 32'd1 || out_instr !== 32'hA000_0001) begin n_fail++; $display("FAIL bp_second: got pc %0d instr %h want 1 a0000001", out_pc, out_instr); end
        n_checks++; if (A !== 32'sd3) begin n_fail++; $display("FAIL bp_resume_A: got %0d want 3", A); end
        step();
        n_checks++; if (out_pc !== 32'd2 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_third: got pc %0d v %0b want 2 1", out_pc, out_valid); end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        step(); step(); step();
        out_ready = 1'b0;
        step(); step();
        n_checks++; if (out_pc !== 32'd2 || A !== 32'sd4) begin n_fail++; $display("FAIL redir_setup: got pc %0d A %0d want 2 4", out_pc, A); end
        redirect = 1'b1;
        redirect_target = 1;
        out_ready = 1'b1;
        step();
        redirect = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || A !== 32'sd1) begin n_fail++; $display("FAIL redir_flush: got v %0b A %0d want 0 1", out_valid, A); end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'd1 || out_instr !== 32'hA000_0001) begin n_fail++; $display("FAIL redir_first: got v %0b pc %0d instr %h want 1 1 a0000001", out_valid, out_pc, out_instr); end
        step();
        n_checks++; if (out_pc !== 32'd2 || out_instr !== 32'hA000_0002) begin n_fail++; $display("FAIL redir_next: got pc %0d instr %h want 2 a0000002", out_pc, out_instr); end
    endtask

    task automatic test_fault();
        do_reset(1'b1);
        step(); step();
        redirect = 1'b1;
        redirect_target = 7;
        step();
        redirect = 1'b0;
        n_checks++; if (fault !== 1'b1 || halted !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fault_enter: got f %0b h %0b v %0b want 1 1 0", fault, halted, out_valid); end
        n_checks++; if (A !== 32'sd2) begin n_fail++; $display("FAIL fault_pc_hold: got %0d want 2", A); end
        redirect = 1'b1;
        redirect_target = 0;
        step();
        redirect = 1'b0;
        step();
        n_checks++; if (fault !== 1'b1 || out_valid !== 1'b0 || A !== 32'sd2) begin n_fail++; $display("FAIL fault_sticky: got f %0b v %0b A %0d want 1 0 2", fault, out_valid, A); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        step(); step(); step();
        n_checks++; if (out_valid !== 1'b1 || A !== 32'sd2) begin n_fail++; $display("FAIL areset_full: got v %0b A %0d want 1 2", out_valid, A); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || A !== 32'sd0) begin n_fail++; $display("FAIL areset_now: got v %0b A %0d want 0 0", out_valid, A); end
        n_checks++; if (out_pc !== 32'd0 || out_instr !== 32'd0 || halted !== 1'b0) begin n_fail++; $display("FAIL areset_out: got pc %0d instr %h h %0b want 0 0 0", out_pc, out_instr, halted); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_done_redirect();
        int waited;
        do_reset(1'b1);
        waited = 0;
        while (halted !== 1'b1 && waited < 20) begin step(); waited++; end
        n_checks++; if (halted !== 1'b1 || A !== 32'sd5) begin n_fail++; $display("FAIL done_reach: got h %0b A %0d want 1 5", halted, A); end
        redirect = 1'b1;
        redirect_target = 3;
        step();
        redirect = 1'b0;
        n_checks++; if (halted !== 1'b0 || A !== 32'sd3) begin n_fail++; $display("FAIL done_redir: got h %0b A %0d want 0 3", halted, A); end
        step();
        n_checks++; if (out_pc !== 32'd3 || out_instr !== 32'hA000_0003) begin n_fail++; $display("FAIL done_pc3: got pc %0d instr %h want 3 a0000003", out_pc, out_instr); end
        step();
        n_checks++; if (out_pc !== 32'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL done_pc4: got pc %0d v %0b want 4 1", out_pc, out_valid); end
        waited = 0;
        while (halted !== 1'b1 && waited < 10) begin step(); waited++; end
        n_checks++; if (halted !== 1'b1 || A !== 32'sd5 || fault !== 1'b0) begin n_fail++; $display("FAIL done_again: got h %0b A %0d f %0b want 1 5 0", halted, A, fault); end
    endtask

    initial begin
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_target = 0;
        out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_async_reset();
        test_done_redirect();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DEPTH, default 5: number of 32-bit words in instruction memory; valid word indices are 0..DEPTH-1.
REQ-002 Parameter RESET_PC, default 0: word index of the first fetch after reset.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port A  output  32 (signed): word index driven to instruction memory, which returns RD combinationally in the same cycle.
REQ-006 Port RD  input  32: instruction word from instruction memory for the current A.
REQ-007 Port redirect  input  1: branch/jump request, one-cycle pulse.
REQ-008 Port redirect_target  input  32 (signed): new word index, sampled when redirect=1.
REQ-009 Port out_valid  output  1: out_instr/out_pc hold a valid fetched instruction.
REQ-010 Port out_ready  input  1: decoder accepts the head entry when out_valid=1 and out_ready=1.
REQ-011 Port out_instr  output  32: head instruction word.
REQ-012 Port out_pc  output  32: word index the head instruction was fetched from.
REQ-013 Port halted  output  1: high in DONE or FAULT.
REQ-014 Port fault  output  1: high only in FAULT.

Function
REQ-015 State register pc (32-bit signed); A SHALL equal pc combinationally at all times.
REQ-016 2-entry FIFO of {instr, pc}; out_valid = FIFO non-empty; out_instr/out_pc = head entry.
REQ-017 States: RUN, DRAIN, DONE, FAULT.
REQ-018 RUN, fetch cycle: FIFO not full after this cycle's pop, and redirect=0 -> push {RD, pc}; pc <= pc+1.
REQ-019 RUN, FIFO full with no pop: no push; pc and A held (stall).
REQ-020 RUN: pc+1 = DEPTH on a fetch -> DRAIN after the push.
REQ-021 DRAIN: no pushes; on FIFO empty -> DONE.
REQ-022 DONE: no pushes; pc held at DEPTH; left only via redirect or reset.
REQ-023 Redirect (RUN, DRAIN or DONE): FIFO flushed (a pop in the same cycle is ignored; no push); target in 0..DEPTH-1 -> pc <= target, RUN; out of range -> pc held, FAULT.
REQ-024 Redirect takes priority over fetch and pop in the same cycle; first post-redirect instruction appears on out_* one cycle after the redirect cycle.
REQ-025 FAULT: FIFO empty, out_valid=0, fault=1, halted=1; redirect ignored; exit only by reset.
REQ-026 Push and pop in the same cycle with a full FIFO are allowed (throughput 1 instr/cycle).
REQ-027 Pointer arithmetic: 1-bit read/write pointers wrap modulo 2; 2-bit count 0..2, never exceeds 2.
REQ-028 Fetch-to-out latency: instruction at pc is visible on out_* the cycle after the push cycle.

Reset
REQ-029 rst_n=0 at any time (including mid-fetch or mid-redirect): immediately pc=RESET_PC, FIFO empty, out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0, state RUN.
REQ-030 First push occurs in the first rising clk edge with rst_n=1.

Verification
REQ-031 Memory {I0..I4}, DEPTH=5, out_ready=1 -> out_pc 0,1,2,3,4 on consecutive cycles with I0..I4, then out_valid=0, halted=1, A=5 held.
REQ-032 out_ready=0 for 4 cycles after reset -> FIFO holds pc 0,1; A stays 2; on out_ready=1 outputs pc 0,1,2 with no skip or duplicate.
REQ-033 Redirect to 1 while FIFO holds pc 2,3 -> entries dropped; next out_pc=1, out_instr=I1, then 2.
REQ-034 Redirect to 7 (DEPTH=5) -> fault=1, halted=1, out_valid=0; a later redirect to 0 has no effect.
REQ-035 Assert rst_n=0 between clock edges while FIFO full -> out_valid=0 and A=0 immediately, before the next edge.
REQ-036 In DONE, redirect to 3 -> halted=0; out_pc 3,4, then DONE again.
